simple3_sweep_ctrl: RTL and testbench

//  Sequencer for the simple3 datapath (A[3:0], D in; B[3:0], E[3:0] out).
//  - On start, sweeps {D,A} through all 32 codes, 31 down to 0.
//  - Holds each code for a settle window, then samples B/E.
//  - Streams each sample out and folds it into a 16-bit MISR signature.
//  - Sits between a host or self-test controller and one simple3 instance.

---
 rtl/simple3_pkg.sv | 23 ++
 rtl/simple3_sweep_ctrl_if.sv | 12 +
 rtl/simple3_misr.sv | 22 ++
 rtl/simple3_sweep_ctrl.sv | 108 ++++++++++
 tb/tb_simple3_sweep_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple3_pkg.sv
// Shared constants, FSM state type and MISR step function for the simple3 sweep sequencer.
package simple3_pkg;

   localparam int CODE_W    = 5;
   localparam int NUM_CODES = 32;
   localparam int SIG_W     = 16;

   // Feedback taps at bits 15, 14, 12 and 3.
   localparam logic [SIG_W-1:0] MISR_TAPS = 16'hD008;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_t;

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                  input logic [7:0]       din);
      return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ {8'h00, din};
   endfunction

endpackage

// File: rtl/simple3_sweep_ctrl_if.sv
// Pin-level bus between the sweep sequencer and one simple3 datapath instance.
interface simple3_sweep_ctrl_if;

   logic [3:0] dut_a;
   logic       dut_d;
   logic [3:0] dut_b;
   logic [3:0] dut_e;

   modport master (output dut_a, output dut_d, input dut_b, input dut_e);
   modport slave  (input dut_a, input dut_d, output dut_b, output dut_e);

endinterface

// File: rtl/simple3_misr.sv
// 16-bit multiple-input signature register folding one 8-bit sample per enable.
module simple3_misr
   import simple3_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [SIG_W-1:0] seed,
   input  logic             en,
   input  logic [7:0]       din,
   output logic [SIG_W-1:0] sig
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sig <= seed;
      end else if (en) begin
         sig <= misr_step(sig, din);
      end
   end

endmodule

// File: rtl/simple3_sweep_ctrl.sv
// Sweeps {D,A} from 31 down to 0, samples B/E after a settle window and signs the results.
module simple3_sweep_ctrl
   import simple3_pkg::*;
#(
   parameter int               HOLD_CYCLES = 2,
   parameter logic [SIG_W-1:0] MISR_SEED   = 16'h0000
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   simple3_sweep_ctrl_if.master bus,
   output logic                 busy,
   output logic                 smp_valid,
   output logic [CODE_W-1:0]    smp_code,
   output logic [3:0]           smp_b,
   output logic [3:0]           smp_e,
   output logic                 done,
   output logic [SIG_W-1:0]     signature
);

   localparam int                CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CODE_W-1:0] CODE_TOP = CODE_W'(NUM_CODES - 1);

   sweep_state_t      state;
   logic [CODE_W-1:0] code;
   logic [CNT_W-1:0]  cnt;
   logic              start_ok;
   logic              sample_fire;

   // Abort dominates start, and start is only honoured while not busy.
   assign start_ok    = start && !abort && ((state == IDLE) || (state == DONE));
   assign sample_fire = (state == SAMPLE) && !abort;

   assign busy      = (state == SETTLE) || (state == SAMPLE);
   assign bus.dut_a = code[3:0];
   assign bus.dut_d = code[4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         code      <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         smp_valid <= 1'b0;
         smp_code  <= '0;
         smp_b     <= '0;
         smp_e     <= '0;
      end else begin
         // NOTE: strobe defaults low each cycle; only a completed SAMPLE raises it, so no stale pulse survives.
         smp_valid <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  state <= SETTLE;
                  code  <= CODE_TOP;
                  cnt   <= '0;
                  done  <= 1'b0;
               end else if (state == DONE) begin
                  done <= 1'b1;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state <= IDLE;
                  code  <= '0;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SAMPLE: begin
               cnt <= '0;
               if (abort) begin
                  state <= IDLE;
                  code  <= '0;
               end else begin
                  smp_valid <= 1'b1;
                  smp_code  <= code;
                  smp_b     <= bus.dut_b;
                  smp_e     <= bus.dut_e;
                  if (code == '0) begin
                     state <= DONE;
                  end else begin
                     state <= SETTLE;
                     code  <= code - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   simple3_misr u_misr (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_ok),
      .seed (MISR_SEED),
      .en   (sample_fire),
      .din  ({bus.dut_b, bus.dut_e}),
      .sig  (signature)
   );

endmodule

// File: tb/tb_simple3_sweep_ctrl.sv
// Scoreboard bench for simple3_sweep_ctrl with a behavioural simple3 stand-in on the pin bus.
module tb_simple3_sweep_ctrl;
   import simple3_pkg::*;

   typedef struct packed {
      logic [4:0] code;
      logic [3:0] b;
      logic [3:0] e;
   } smp_t;

   logic clk = 1'b0;
   logic rst, start, abort;
   always #5 clk = ~clk;

   simple3_sweep_ctrl_if bus ();
   simple3_sweep_ctrl_if bus1 ();
   simple3_sweep_ctrl_if bus5 ();

   logic        busy, smp_valid, done;
   logic [4:0]  smp_code;
   logic [3:0]  smp_b, smp_e;
   logic [15:0] signature;
   logic        busy1, smp_valid1, done1, busy5, smp_valid5, done5;
   logic [4:0]  smp_code1, smp_code5;
   logic [3:0]  smp_b1, smp_e1, smp_b5, smp_e5;
   logic [15:0] signature1, signature5;

   int          mode;
   logic [7:0]  dp_be;

   // Stand-in datapath: 0 = all zero, 1 = B=1 only at code 0, 2 = loopback B=A, E=~A.
   function automatic logic [7:0] dp_model(input int m, input logic [4:0] c);
      case (m)
         1:       return (c == 5'd0) ? 8'h10 : 8'h00;
         2:       return {c[3:0], ~c[3:0]};
         default: return 8'h00;
      endcase
   endfunction

   assign dp_be      = dp_model(mode, {bus.dut_d, bus.dut_a});
   assign bus.dut_b  = dp_be[7:4];
   assign bus.dut_e  = dp_be[3:0];
   assign bus1.dut_b = 4'h0;
   assign bus1.dut_e = 4'h0;
   assign bus5.dut_b = 4'h0;
   assign bus5.dut_e = 4'h0;

   simple3_sweep_ctrl #(.HOLD_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
      .busy(busy), .smp_valid(smp_valid), .smp_code(smp_code), .smp_b(smp_b),
      .smp_e(smp_e), .done(done), .signature(signature));

   simple3_sweep_ctrl #(.HOLD_CYCLES(1)) dut_h1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus1),
      .busy(busy1), .smp_valid(smp_valid1), .smp_code(smp_code1), .smp_b(smp_b1),
      .smp_e(smp_e1), .done(done1), .signature(signature1));

   simple3_sweep_ctrl #(.HOLD_CYCLES(5)) dut_h5 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus5),
      .busy(busy5), .smp_valid(smp_valid5), .smp_code(smp_code5), .smp_b(smp_b5),
      .smp_e(smp_e5), .done(done5), .signature(signature5));

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          start_cyc;
   int          strobes, strobes1, strobes5;
   smp_t        exp_q[$];
   smp_t        ent;
   logic [15:0] exp_sig;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [7:0] din);
      logic fb;
      fb = s[15] ^ s[14] ^ s[12] ^ s[3];
      return {s[14:0], fb} ^ {8'h00, din};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every strobe pops one expected sample and folds it into the reference signature.
   always @(negedge clk) begin
      if (!rst && smp_valid) begin
         strobes++;
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", {27'd0, smp_code}, 32'hffff_ffff);
         end else begin
            ent = exp_q.pop_front();
            check("smp_code", {27'd0, smp_code}, {27'd0, ent.code});
            check("smp_b", {28'd0, smp_b}, {28'd0, ent.b});
            check("smp_e", {28'd0, smp_e}, {28'd0, ent.e});
            exp_sig = ref_misr(exp_sig, {ent.b, ent.e});
         end
      end
      if (!rst && smp_valid1) strobes1++;
      if (!rst && smp_valid5) strobes5++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sweep();
      logic [7:0] be;
      exp_q.delete();
      for (int c = 31; c >= 0; c--) begin
         be = dp_model(mode, 5'(c));
         exp_q.push_back('{code: 5'(c), b: be[7:4], e: be[3:0]});
      end
      exp_sig  = 16'h0000;
      strobes  = 0;
      strobes1 = 0;
      strobes5 = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic run_to_done(output int lat);
      lat = -1;
      for (int n = 0; n < 400; n++) begin
         if (done) begin
            lat = cyc - start_cyc;
            break;
         end
         tick();
      end
   endtask

   task automatic finish_sweep(input string tag);
      int lat;
      run_to_done(lat);
      check({tag, "_latency"}, lat, 97);
      check({tag, "_strobes"}, strobes, 32);
      check({tag, "_queue_left"}, exp_q.size(), 0);
      check({tag, "_signature"}, {16'd0, signature}, {16'd0, exp_sig});
      check({tag, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      int lat1, lat2, lat5;
      mode  = 0;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      strobes = 0; strobes1 = 0; strobes5 = 0;
      exp_sig = 16'h0000;
      repeat (3) tick();
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_valid", {31'd0, smp_valid}, 0);
      check("rst_code_pins", {27'd0, bus.dut_d, bus.dut_a}, 0);
      check("rst_signature", {16'd0, signature}, 0);
      rst = 1'b0;
      tick();

      // 1: all-zero datapath
      mode = 0;
      start_sweep();
      check("t1_busy_after_start", {31'd0, busy}, 1);
      check("t1_first_code_pins", {27'd0, bus.dut_d, bus.dut_a}, 31);
      finish_sweep("t1");
      check("t1_signature_const", {16'd0, signature}, 32'h0000);

      // 2: single nonzero B at code 0, then restart from DONE
      mode = 1;
      start_sweep();
      finish_sweep("t2");
      check("t2_signature_const", {16'd0, signature}, 32'h0010);
      check("t2_last_code", {27'd0, smp_code}, 0);
      check("t2_last_b", {28'd0, smp_b}, 1);
      check("t2_last_e", {28'd0, smp_e}, 0);
      tick();
      check("t2_done_held", {31'd0, done}, 1);
      start_sweep();
      check("t2_restart_done_clr", {31'd0, done}, 0);
      check("t2_restart_sig_clr", {16'd0, signature}, 0);
      finish_sweep("t2b");

      // 3: loopback, then abort while DONE has no effect
      mode = 2;
      start_sweep();
      finish_sweep("t3");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      check("t3_abort_idle_done", {31'd0, done}, 1);
      check("t3_abort_idle_sig", {16'd0, signature}, {16'd0, exp_sig});

      // 4: abort with start during the 10th SAMPLE cycle
      start_sweep();
      repeat (29) tick();
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("t4_abort_busy", {31'd0, busy}, 0);
      check("t4_abort_pins", {27'd0, bus.dut_d, bus.dut_a}, 0);
      check("t4_abort_done", {31'd0, done}, 0);
      repeat (6) tick();
      check("t4_abort_strobes", strobes, 9);
      check("t4_abort_queue", exp_q.size(), 23);
      check("t4_abort_sig", {16'd0, signature}, {16'd0, exp_sig});
      check("t4_still_idle", {31'd0, busy}, 0);
      start_sweep();
      finish_sweep("t4b");

      // 5: start pulses while busy are ignored; then reset mid-sweep
      start_sweep();
      for (int k = 0; k < 6; k++) begin
         repeat (6) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      finish_sweep("t5");
      start_sweep();
      repeat (40) tick();
      rst = 1'b1;
      tick();
      check("t5_rst_busy", {31'd0, busy}, 0);
      check("t5_rst_pins", {27'd0, bus.dut_d, bus.dut_a}, 0);
      check("t5_rst_valid", {31'd0, smp_valid}, 0);
      check("t5_rst_smp", {19'd0, smp_code, smp_b, smp_e}, 0);
      check("t5_rst_sig", {16'd0, signature}, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (4) tick();
      check("t5_rst_stays_idle", {31'd0, busy}, 0);

      // 6: latency across hold settings
      mode = 0;
      start_sweep();
      lat1 = -1; lat2 = -1; lat5 = -1;
      for (int n = 0; n < 400; n++) begin
         if (done1 && lat1 < 0) lat1 = cyc - start_cyc;
         if (done  && lat2 < 0) lat2 = cyc - start_cyc;
         if (done5 && lat5 < 0) lat5 = cyc - start_cyc;
         if (lat1 >= 0 && lat2 >= 0 && lat5 >= 0) break;
         tick();
      end
      check("t6_latency_h1", lat1, 65);
      check("t6_latency_h2", lat2, 97);
      check("t6_latency_h5", lat5, 193);
      check("t6_strobes_h1", strobes1, 32);
      check("t6_strobes_h5", strobes5, 32);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
